rps_referee: RTL and testbench
==============================

RPS_REFEREE -- requirements
Module: rps_referee

Interface
REQ-001 The block SHALL have parameter MAX_GAMES, default 60, meaning the number of rounds in one match.
REQ-002 The block SHALL have parameter TIMEOUT_CYCLES, default 8191, meaning the maximum cycles spent waiting for any engine handshake edge.
REQ-003 The block SHALL have port clock, input, 1 bit, system clock; all state changes occur on its rising edge.
REQ-004 The block SHALL have port reset, input, 1 bit, asynchronous, active-low.
REQ-005 The block SHALL have port btn_valid, input, 1 bit, one-cycle pulse marking a player move.
REQ-006 The block SHALL have port btn_choice, input, 2 bits, player move (00 rock, 01 scissors, 10 paper, 11 illegal).
REQ-007 The block SHALL have port eng_choice, input, 2 bits, learning engine move, same encoding.
REQ-008 The block SHALL have port eng_ready, input, 1 bit, engine result-valid flag.
REQ-009 The block SHALL have port start, output, 1 bit, compute request to the engine; a falling edge acknowledges the result.
REQ-010 The block SHALL have port user_choice, output, 2 bits, latched player move presented to the engine.
REQ-011 The block SHALL have port result, output, 2 bits, last outcome (00 draw, 01 player win, 10 engine win).
REQ-012 The block SHALL have port result_valid, output, 1 bit, one-cycle pulse when result updates.
REQ-013 The block SHALL have ports game_count, user_wins, comp_wins and draws, each output, 6 bits; they are the match counters.
REQ-014 The block SHALL have ports busy, done and timeout_err, each output, 1 bit; they are status flags.

Function
REQ-015 The FSM SHALL have states IDLE, REQ, JUDGE, ACK, DONE and ERR.
REQ-016 In IDLE, a btn_valid with a legal btn_choice SHALL latch user_choice and enter REQ; start SHALL be 1 on the next cycle.
REQ-017 A btn_valid in IDLE with btn_choice=11 SHALL be ignored, and no state SHALL change.
REQ-018 A btn_valid in any state other than IDLE SHALL be ignored.
REQ-019 In REQ, start SHALL be held at 1 and user_choice SHALL be held stable; eng_ready=1 sampled at edge M SHALL latch eng_choice and enter JUDGE.
REQ-020 In the cycle after edge M, JUDGE SHALL drive result and pulse result_valid for one cycle, and start SHALL be 0.
REQ-021 In the same cycle, JUDGE SHALL increment exactly one of user_wins, comp_wins or draws, and SHALL increment game_count.
REQ-022 The player SHALL win with rock vs scissors, scissors vs paper and paper vs rock; the engine SHALL win on the mirrored pairs; equal moves SHALL be a draw.
REQ-023 An engine move of 11 SHALL be scored as a player win (forfeit).
REQ-024 JUDGE SHALL always go to ACK; ACK SHALL wait for eng_ready=0.
REQ-025 On leaving ACK, the FSM SHALL enter DONE if game_count==MAX_GAMES, and IDLE otherwise.
REQ-026 DONE SHALL hold done=1, SHALL hold every counter, and SHALL ignore all inputs until reset.
REQ-027 A timeout counter SHALL clear on entry to REQ and to ACK, and SHALL increment every cycle in those states.
REQ-028 When the timeout counter reaches TIMEOUT_CYCLES, the FSM SHALL enter ERR.
REQ-029 ERR SHALL set timeout_err=1 (sticky), set start=0, freeze all counters, and exit only on reset.
REQ-030 busy SHALL be 1 in REQ, JUDGE and ACK, and 0 otherwise.
REQ-031 Counter arithmetic SHALL be unsigned 6-bit; by construction, no counter SHALL exceed MAX_GAMES (which is at most 63).
REQ-032 If eng_ready is already 1 on entry to REQ, it SHALL be accepted at the first edge in REQ.

Reset
REQ-033 While reset=0, the state SHALL be IDLE, and start, result_valid, busy, done and timeout_err SHALL be 0.
REQ-034 While reset=0, user_choice, result and all counters SHALL be 0, and the timeout counter SHALL be 0.
REQ-035 Reset asserted mid-round SHALL abort the round immediately, with no counter update, and start SHALL drop asynchronously.

Structure
REQ-036 The move encodings, result encodings, MAX_GAMES and TIMEOUT_CYCLES defaults SHALL reside in shared package rps_pkg, which is reused by the engine modules.
REQ-037 Outcome logic SHALL be one combinational sub-module, rps_judge (inputs: player move and engine move; output: result).
REQ-038 rps_referee SHALL contain the FSM, the counters and the timeout logic.

Verification
REQ-039 Bench SHALL cover: btn rock (00); engine returns paper (10) 5 cycles later -> start high for 6 cycles, result=10, comp_wins=1, game_count=1, result_valid one cycle.
REQ-040 Bench SHALL cover: btn 11 in IDLE -> start stays 0, all counters 0; then btn scissors vs engine paper -> result=01, user_wins=1.
REQ-041 Bench SHALL cover: 60 rounds of paper vs paper -> draws=60, game_count=60, done=1; a 61st btn_valid leaves start=0.
REQ-042 Bench SHALL cover: eng_ready never rises -> timeout_err=1 after 8191 cycles in REQ, start=0, counters unchanged.
REQ-043 Bench SHALL cover: reset pulse while in REQ -> start=0 asynchronously, all outputs 0, next btn accepted normally.
REQ-044 Bench SHALL cover: btn_valid pulses during REQ/ACK -> ignored; user_choice unchanged; exactly one count increments per round.

Source files
------------

// File: rtl/rps_pkg.sv
// Shared rock-paper-scissors encodings and defaults, also used by the engine modules.
package rps_pkg;

  typedef enum logic [1:0] {
    MvRock     = 2'b00,
    MvScissors = 2'b01,
    MvPaper    = 2'b10,
    MvIllegal  = 2'b11
  } move_e;

  typedef enum logic [1:0] {
    ResDraw   = 2'b00,
    ResPlayer = 2'b01,
    ResEngine = 2'b10
  } result_e;

  localparam int unsigned MaxGamesDefault      = 60;
  localparam int unsigned TimeoutCyclesDefault = 8191;

  function automatic logic player_beats(logic [1:0] p, logic [1:0] e);
    return (p == MvRock     && e == MvScissors) ||
           (p == MvScissors && e == MvPaper)    ||
           (p == MvPaper    && e == MvRock);
  endfunction

endpackage

// File: rtl/rps_judge.sv
// Combinational round outcome; an illegal engine move forfeits to the player.
module rps_judge
  import rps_pkg::*;
(
  input  logic [1:0] player_i,
  input  logic [1:0] engine_i,
  output logic [1:0] result_o
);

  always_comb begin
    result_o = ResEngine;
    if (engine_i == MvIllegal) begin
      result_o = ResPlayer;
    end else if (player_i == engine_i) begin
      result_o = ResDraw;
    end else if (player_beats(player_i, engine_i)) begin
      result_o = ResPlayer;
    end
  end

endmodule

// File: rtl/rps_referee.sv
// Match referee: handshakes with the learning engine, scores rounds, keeps match counters.
module rps_referee
  import rps_pkg::*;
#(
  parameter int unsigned MAX_GAMES      = MaxGamesDefault,
  parameter int unsigned TIMEOUT_CYCLES = TimeoutCyclesDefault
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       btn_valid,
  input  logic [1:0] btn_choice,
  input  logic [1:0] eng_choice,
  input  logic       eng_ready,
  output logic       start,
  output logic [1:0] user_choice,
  output logic [1:0] result,
  output logic       result_valid,
  output logic [5:0] game_count,
  output logic [5:0] user_wins,
  output logic [5:0] comp_wins,
  output logic [5:0] draws,
  output logic       busy,
  output logic       done,
  output logic       timeout_err
);

  localparam int unsigned TmoW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [TmoW-1:0] TmoLast = TmoW'(TIMEOUT_CYCLES - 1);

  typedef enum logic [2:0] {StIdle, StReq, StJudge, StAck, StDone, StErr} state_e;

  state_e            state_q, state_d;
  logic [TmoW-1:0]   tmo_q, tmo_d;
  logic [1:0]        user_q, user_d;
  logic [1:0]        result_q, result_d;
  logic [5:0]        games_q, games_d;
  logic [5:0]        uwins_q, uwins_d;
  logic [5:0]        cwins_q, cwins_d;
  logic [5:0]        draws_q, draws_d;
  logic [1:0]        judge_res;

  // Judged against the live engine move so the outcome lands at the accepting edge.
  rps_judge u_judge (
    .player_i (user_q),
    .engine_i (eng_choice),
    .result_o (judge_res)
  );

  always_comb begin
    state_d  = state_q;
    tmo_d    = tmo_q;
    user_d   = user_q;
    result_d = result_q;
    games_d  = games_q;
    uwins_d  = uwins_q;
    cwins_d  = cwins_q;
    draws_d  = draws_q;
    case (state_q)
      StIdle: begin
        if (btn_valid && btn_choice != MvIllegal) begin
          user_d  = btn_choice;
          tmo_d   = '0;
          state_d = StReq;
        end
      end
      StReq: begin
        if (eng_ready) begin
          state_d  = StJudge;
          result_d = judge_res;
          games_d  = games_q + 6'd1;
          case (judge_res)
            ResDraw:   draws_d = draws_q + 6'd1;
            ResPlayer: uwins_d = uwins_q + 6'd1;
            ResEngine: cwins_d = cwins_q + 6'd1;
            default: ;
          endcase
        end else if (tmo_q == TmoLast) begin
          state_d = StErr;
        end else begin
          tmo_d = tmo_q + TmoW'(1);
        end
      end
      StJudge: begin
        tmo_d   = '0;
        state_d = StAck;
      end
      StAck: begin
        if (!eng_ready) begin
          state_d = (games_q == 6'(MAX_GAMES)) ? StDone : StIdle;
        end else if (tmo_q == TmoLast) begin
          state_d = StErr;
        end else begin
          tmo_d = tmo_q + TmoW'(1);
        end
      end
      StDone, StErr: ;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q  <= StIdle;
      tmo_q    <= '0;
      user_q   <= '0;
      result_q <= '0;
      games_q  <= '0;
      uwins_q  <= '0;
      cwins_q  <= '0;
      draws_q  <= '0;
    end else begin
      state_q  <= state_d;
      tmo_q    <= tmo_d;
      user_q   <= user_d;
      result_q <= result_d;
      games_q  <= games_d;
      uwins_q  <= uwins_d;
      cwins_q  <= cwins_d;
      draws_q  <= draws_d;
    end
  end

  // Status outputs decode straight from the state so reset clears them asynchronously.
  assign start        = (state_q == StReq);
  assign result_valid = (state_q == StJudge);
  assign busy         = (state_q == StReq) || (state_q == StJudge) || (state_q == StAck);
  assign done         = (state_q == StDone);
  assign timeout_err  = (state_q == StErr);
  assign user_choice  = user_q;
  assign result       = result_q;
  assign game_count   = games_q;
  assign user_wins    = uwins_q;
  assign comp_wins    = cwins_q;
  assign draws        = draws_q;

endmodule

// File: tb/tb_rps_referee.sv
// Self-checking bench for rps_referee: vector table, hand sequences, randomized rounds.
module tb_rps_referee;

  logic       clock = 1'b0;
  logic       reset = 1'b0;
  logic       btn_valid = 1'b0;
  logic [1:0] btn_choice = 2'b00;
  logic [1:0] eng_choice = 2'b00;
  logic       eng_ready = 1'b0;
  logic       start, result_valid, busy, done, timeout_err;
  logic [1:0] user_choice, result;
  logic [5:0] game_count, user_wins, comp_wins, draws;

  int n_checks = 0;
  int n_errors = 0;
  int m_games, m_user, m_comp, m_draw;

  typedef struct {
    int p;
    int e;
    int exp_res;
  } vec_t;

  vec_t vecs[12];

  rps_referee dut (
    .clock        (clock),
    .reset        (reset),
    .btn_valid    (btn_valid),
    .btn_choice   (btn_choice),
    .eng_choice   (eng_choice),
    .eng_ready    (eng_ready),
    .start        (start),
    .user_choice  (user_choice),
    .result       (result),
    .result_valid (result_valid),
    .game_count   (game_count),
    .user_wins    (user_wins),
    .comp_wins    (comp_wins),
    .draws        (draws),
    .busy         (busy),
    .done         (done),
    .timeout_err  (timeout_err)
  );

  always #5 clock = ~clock;

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_errors++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // Reference: 0 draw, 1 player, 2 engine. Cyclic order rock->scissors->paper->rock.
  function automatic int ref_outcome(int p, int e);
    if (e == 3) return 1;
    if (p == e) return 0;
    if (((e - p + 3) % 3) == 1) return 1;
    return 2;
  endfunction

  task automatic model_clear();
    m_games = 0; m_user = 0; m_comp = 0; m_draw = 0;
  endtask

  task automatic check_counts(input string tag);
    check({tag, " game_count"}, int'(game_count), m_games);
    check({tag, " user_wins"},  int'(user_wins),  m_user);
    check({tag, " comp_wins"},  int'(comp_wins),  m_comp);
    check({tag, " draws"},      int'(draws),      m_draw);
  endtask

  task automatic do_reset();
    #1;
    reset = 1'b0;
    btn_valid = 1'b0;
    eng_ready = 1'b0;
    tick();
    tick();
    reset = 1'b1;
    model_clear();
  endtask

  task automatic play_round(input int p, input int e, input int lat, input bit noise,
                            input int exp_res);
    int starts;
    starts = 0;
    btn_valid  = 1'b1;
    btn_choice = 2'(p);
    tick();
    btn_valid = 1'b0;
    for (int i = 0; i < lat; i++) begin
      if (start) starts++;
      if (noise) begin
        btn_valid  = 1'b1;
        btn_choice = 2'(p) ^ 2'b01;
      end
      tick();
      btn_valid = 1'b0;
    end
    if (start) starts++;
    check("start high cycles", starts, lat + 1);
    eng_ready  = 1'b1;
    eng_choice = 2'(e);
    tick();
    case (exp_res)
      0: m_draw++;
      1: m_user++;
      default: m_comp++;
    endcase
    m_games++;
    check("judge start", int'(start), 0);
    check("judge result_valid", int'(result_valid), 1);
    check("judge result", int'(result), exp_res);
    check("judge user_choice", int'(user_choice), p);
    check_counts("judge");
    if (noise) begin
      btn_valid  = 1'b1;
      btn_choice = 2'(p) ^ 2'b10;
      tick();
      check("ack result_valid", int'(result_valid), 0);
      tick();
      btn_valid = 1'b0;
      eng_ready = 1'b0;
      tick();
    end else begin
      eng_ready = 1'b0;
      tick();
      check("ack result_valid", int'(result_valid), 0);
      tick();
    end
    check("post busy", int'(busy), 0);
    check("post start", int'(start), 0);
    check("post user_choice", int'(user_choice), p);
    check_counts("post");
  endtask

  initial begin
    vecs[0]  = '{p: 0, e: 0, exp_res: 0};
    vecs[1]  = '{p: 0, e: 1, exp_res: 1};
    vecs[2]  = '{p: 0, e: 2, exp_res: 2};
    vecs[3]  = '{p: 1, e: 0, exp_res: 2};
    vecs[4]  = '{p: 1, e: 1, exp_res: 0};
    vecs[5]  = '{p: 1, e: 2, exp_res: 1};
    vecs[6]  = '{p: 2, e: 0, exp_res: 1};
    vecs[7]  = '{p: 2, e: 1, exp_res: 2};
    vecs[8]  = '{p: 2, e: 2, exp_res: 0};
    vecs[9]  = '{p: 0, e: 3, exp_res: 1};
    vecs[10] = '{p: 1, e: 3, exp_res: 1};
    vecs[11] = '{p: 2, e: 3, exp_res: 1};

    // Reset state
    model_clear();
    tick();
    check("rst start", int'(start), 0);
    check("rst result_valid", int'(result_valid), 0);
    check("rst busy", int'(busy), 0);
    check("rst done", int'(done), 0);
    check("rst timeout_err", int'(timeout_err), 0);
    check("rst user_choice", int'(user_choice), 0);
    check("rst result", int'(result), 0);
    check_counts("rst");
    do_reset();

    // Illegal button move is ignored
    btn_valid  = 1'b1;
    btn_choice = 2'b11;
    tick();
    btn_valid = 1'b0;
    check("illegal start", int'(start), 0);
    check("illegal busy", int'(busy), 0);
    tick();
    check("illegal start later", int'(start), 0);
    check_counts("illegal");

    play_round(1, 2, 2, 1'b0, 1);
    play_round(0, 2, 5, 1'b0, 2);
    play_round(2, 0, 3, 1'b1, 1);

    for (int i = 0; i < 12; i++) begin
      play_round(vecs[i].p, vecs[i].e, i % 3, (i % 2) == 1, vecs[i].exp_res);
    end

    for (int i = 0; i < 30; i++) begin
      int p, e, lat;
      bit noise;
      p     = int'($urandom_range(0, 2));
      e     = int'($urandom_range(0, 3));
      lat   = int'($urandom_range(0, 4));
      noise = 1'($urandom_range(0, 1));
      play_round(p, e, lat, noise, ref_outcome(p, e));
    end

    // Reset mid-REQ aborts the round
    btn_valid  = 1'b1;
    btn_choice = 2'b10;
    tick();
    btn_valid = 1'b0;
    check("pre-abort start", int'(start), 1);
    reset = 1'b0;
    #1;
    check("abort start async", int'(start), 0);
    check("abort busy", int'(busy), 0);
    check("abort user_choice", int'(user_choice), 0);
    check("abort result", int'(result), 0);
    model_clear();
    check_counts("abort");
    tick();
    reset = 1'b1;
    play_round(0, 1, 1, 1'b0, 1);

    // Full match of draws
    do_reset();
    for (int i = 0; i < 60; i++) play_round(2, 2, 0, 1'b0, 0);
    check("match done", int'(done), 1);
    btn_valid  = 1'b1;
    btn_choice = 2'b00;
    eng_ready  = 1'b1;
    tick();
    btn_valid = 1'b0;
    tick();
    eng_ready = 1'b0;
    check("done start", int'(start), 0);
    check("done still", int'(done), 1);
    check_counts("done");

    // Engine never answers
    do_reset();
    btn_valid  = 1'b1;
    btn_choice = 2'b01;
    tick();
    btn_valid = 1'b0;
    for (int i = 0; i < 8190; i++) tick();
    check("pre-timeout err", int'(timeout_err), 0);
    check("pre-timeout start", int'(start), 1);
    tick();
    check("timeout err", int'(timeout_err), 1);
    check("timeout start", int'(start), 0);
    check("timeout busy", int'(busy), 0);
    eng_ready  = 1'b1;
    eng_choice = 2'b10;
    tick();
    tick();
    eng_ready = 1'b0;
    check("timeout sticky", int'(timeout_err), 1);
    check("timeout result_valid", int'(result_valid), 0);
    check_counts("timeout");

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
